// File: rtl/ad463x_pkg.sv
// ad463x_pkg: shared FSM states and register-write frame constants for the AD463x sequencer
package ad463x_pkg;
  typedef enum logic [2:0] {RST_HOLD, IDLE, CNV, WAIT_BUSY, READ, REG_WR, QUIET} state_t;
  localparam int REG_FRAME_BITS = 24;
  localparam logic WR_BIT = 1'b0;
endpackage

// File: rtl/ad463x_sck_gen.sv
// ad463x_sck_gen: SCK divider; one setup half-period low, then nbits pulses, done on the last fall
module ad463x_sck_gen #(
  parameter int SCK_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] nbits,
  output logic       sck,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic       done
);
  logic [15:0] div;
  logic [7:0] pulses;
  logic half_end;
  assign half_end = en && div == 16'(SCK_HALF - 1);
  assign rise_tick = half_end && !sck;
  assign fall_tick = half_end && sck;
  assign done = fall_tick && pulses == nbits - 8'd1;
  // free-running half-period counter, cleared whenever the FSM is not shifting
  always_ff @(posedge clk)
    if (rst || !en) begin
      div <= '0;
      pulses <= '0;
      sck <= 1'b0;
    end else begin
      div <= half_end ? '0 : div + 16'd1;
      if (half_end) sck <= !sck;
      if (fall_tick) pulses <= pulses + 8'd1;
    end
endmodule

// File: rtl/ad463x_acq_sequencer.sv
// ad463x_acq_sequencer: AD463x reset/convert/readout and register-write sequencer (option: AD463X_TEST_PATTERN_EN)
module ad463x_acq_sequencer
  import ad463x_pkg::*;
#(
  parameter int NUM_ADCS     = 2,
  parameter int NUM_LANES    = 1,
  parameter int DATA_BITS    = 24,
  parameter int SCK_HALF     = 2,
  parameter int CNV_HIGH     = 4,
  parameter int RST_CYCLES   = 64,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic                              trigger,
  input  logic                              reg_wr_valid,
  input  logic [14:0]                       reg_addr,
  input  logic [7:0]                        reg_data,
  output logic                              reg_wr_ready,
  output logic [NUM_ADCS*DATA_BITS-1:0]     adc_data,
  output logic                              adc_valid,
  output logic                              busy_timeout,
  output logic                              SPI_sck,
  output logic                              SPI_cs,
  output logic                              SPI_cnv,
  output logic                              SPI_reset,
  output logic                              SPI_SDI_data,
  input  logic                              SPI_busy,
`ifdef AD463X_TEST_PATTERN_EN
  input  logic                              test_pattern,
`endif
  input  logic [NUM_ADCS*NUM_LANES-1:0]     SPI_SDn_data
);
  localparam int W = NUM_ADCS * DATA_BITS;
  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] CNV_LAST = 16'(CNV_HIGH - 1);
  localparam logic [15:0] TO_LAST = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] QUIET_LAST = 16'(SCK_HALF - 1);
  state_t state;
  logic [15:0] cnt;
  logic [1:0] busy_sync;
  logic [W-1:0] sh, sh_next, frame;
  logic [REG_FRAME_BITS-1:0] sdi_sh;
  logic en, fall_tick, done, sck_rise_unused;
  logic [7:0] nbits;
`ifdef AD463X_TEST_PATTERN_EN
  logic [DATA_BITS-1:0] tp_cnt;
`endif
  assign en = state == READ || state == REG_WR;
  assign nbits = state == REG_WR ? 8'(REG_FRAME_BITS) : 8'(DATA_BITS / NUM_LANES);
  assign SPI_SDI_data = sdi_sh[REG_FRAME_BITS-1];
  ad463x_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
    .clk(aclk),
    .rst(reset),
    .en(en),
    .nbits(nbits),
    .sck(SPI_sck),
    .rise_tick(sck_rise_unused),
    .fall_tick(fall_tick),
    .done(done)
  );
  // each ADC word shifts left by NUM_LANES; lane 0 lands in the most significant new bit
  always_comb begin
    sh_next = sh;
    for (int k = 0; k < NUM_ADCS; k++) begin
      sh_next[k*DATA_BITS +: DATA_BITS] = sh[k*DATA_BITS +: DATA_BITS] << NUM_LANES;
      for (int l = 0; l < NUM_LANES; l++)
        sh_next[k*DATA_BITS + NUM_LANES - 1 - l] = SPI_SDn_data[k*NUM_LANES + l];
    end
  end
  // word presented at frame end: lanes, or the frame counter when the test pattern is on
  always_comb begin
    frame = sh_next;
`ifdef AD463X_TEST_PATTERN_EN
    for (int k = 0; k < NUM_ADCS; k++)
      if (test_pattern) frame[k*DATA_BITS +: DATA_BITS] = tp_cnt + DATA_BITS'(k);
`endif
  end
  // two-flop synchroniser for the asynchronous BUSY pin
  always_ff @(posedge aclk) busy_sync <= reset ? 2'b00 : {busy_sync[0], SPI_busy};
  // main sequencer; all pin and status outputs registered here
  always_ff @(posedge aclk)
    if (reset) begin
      state <= RST_HOLD;
      cnt <= '0;
      SPI_cs <= 1'b1;
      SPI_cnv <= 1'b0;
      SPI_reset <= 1'b0;
      sdi_sh <= '0;
      sh <= '0;
      adc_data <= '0;
      adc_valid <= 1'b0;
      busy_timeout <= 1'b0;
      reg_wr_ready <= 1'b0;
`ifdef AD463X_TEST_PATTERN_EN
      tp_cnt <= '0;
`endif
    end else begin
      adc_valid <= 1'b0;
      cnt <= cnt + 16'd1;
      case (state)
        RST_HOLD: if (cnt == RST_LAST) begin
          SPI_reset <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          reg_wr_ready <= !trigger && !(reg_wr_valid && reg_wr_ready);
          if (trigger) begin
            state <= CNV;
            SPI_cnv <= 1'b1;
            cnt <= '0;
          end else if (reg_wr_valid && reg_wr_ready) begin
            state <= REG_WR;
            SPI_cs <= 1'b0;
            sdi_sh <= {WR_BIT, reg_addr, reg_data};
          end
        end
        CNV: if (cnt == CNV_LAST) begin
          SPI_cnv <= 1'b0;
          state <= WAIT_BUSY;
          cnt <= '0;
        end
        WAIT_BUSY: if (!busy_sync[1]) begin
          state <= READ;
          SPI_cs <= 1'b0;
        end else if (cnt == TO_LAST) begin
          busy_timeout <= 1'b1;
          state <= IDLE;
        end
        READ: begin
          if (fall_tick) sh <= sh_next;
          if (done) begin
            SPI_cs <= 1'b1;
            adc_data <= frame;
            adc_valid <= 1'b1;
            state <= QUIET;
            cnt <= '0;
`ifdef AD463X_TEST_PATTERN_EN
            tp_cnt <= tp_cnt + 1'b1;
`endif
          end
        end
        REG_WR: begin
          if (fall_tick) sdi_sh <= sdi_sh << 1;
          if (done) begin
            SPI_cs <= 1'b1;
            state <= QUIET;
            cnt <= '0;
          end
        end
        QUIET: if (cnt == QUIET_LAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ad463x_acq_sequencer.sv
// tb_ad463x_acq_sequencer: directed table-driven bench with lane/SDI pin models
module tb_ad463x_acq_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0, wr_valid = 1'b0, busy = 1'b0;
  logic trig2 = 1'b0, busy2 = 1'b0;
  logic [14:0] addr = '0;
  logic [7:0] data = '0;
  logic ready, valid, to, sck, cs, cnv, rstn, sdi;
  logic ready2, valid2, to2, sck2, cs2, cnv2, rstn2, sdi2;
  logic [47:0] adc_data, data2;
  logic [1:0] lanes;
  logic [3:0] lanes2;
  logic [23:0] m0, m1, n0, n1, ld0, ld1;
  logic [23:0] sdi_cap = '0;
  logic ld = 1'b0, psck = 1'b0, psck2 = 1'b0, cs_at_valid = 1'b0;
  int rises = 0, rises2 = 0, valids = 0, valids2 = 0;
  int total = 0, bad = 0, r0, v0, r2, v2, n;
`ifdef AD463X_TEST_PATTERN_EN
  logic tp = 1'b0;
`endif
  typedef struct { logic [23:0] d0, d1; int bdly; logic [47:0] exp; } conv_t;
  typedef struct { logic [14:0] a; logic [7:0] d; logic [23:0] exp; } wr_t;
  conv_t cv[4];
  wr_t wv[2];

  always #5 clk = ~clk;

  assign lanes = {m1[23], m0[23]};
  assign lanes2 = {n1[22], n1[23], n0[22], n0[23]};

  ad463x_acq_sequencer u1 (
    .aclk(clk), .reset(reset), .trigger(trigger), .reg_wr_valid(wr_valid),
    .reg_addr(addr), .reg_data(data), .reg_wr_ready(ready), .adc_data(adc_data),
    .adc_valid(valid), .busy_timeout(to), .SPI_sck(sck), .SPI_cs(cs), .SPI_cnv(cnv),
    .SPI_reset(rstn), .SPI_SDI_data(sdi), .SPI_busy(busy),
`ifdef AD463X_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .SPI_SDn_data(lanes)
  );

  ad463x_acq_sequencer #(.NUM_LANES(2)) u2 (
    .aclk(clk), .reset(reset), .trigger(trig2), .reg_wr_valid(1'b0),
    .reg_addr(addr), .reg_data(data), .reg_wr_ready(ready2), .adc_data(data2),
    .adc_valid(valid2), .busy_timeout(to2), .SPI_sck(sck2), .SPI_cs(cs2), .SPI_cnv(cnv2),
    .SPI_reset(rstn2), .SPI_SDI_data(sdi2), .SPI_busy(busy2),
`ifdef AD463X_TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .SPI_SDn_data(lanes2)
  );

  // ADC pin model: present MSB first, advance after each observed SCK fall
  always @(negedge clk) begin
    psck <= sck;
    psck2 <= sck2;
    if (sck && !psck) begin
      rises <= rises + 1;
      sdi_cap <= {sdi_cap[22:0], sdi};
    end
    if (sck2 && !psck2) rises2 <= rises2 + 1;
    if (valid) begin
      valids <= valids + 1;
      cs_at_valid <= cs;
    end
    if (valid2) valids2 <= valids2 + 1;
    if (ld) begin
      m0 <= ld0; m1 <= ld1; n0 <= ld0; n1 <= ld1;
    end else begin
      if (!sck && psck) begin m0 <= m0 << 1; m1 <= m1 << 1; end
      if (!sck2 && psck2) begin n0 <= n0 << 2; n1 <= n1 << 2; end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_conv(input logic [23:0] d0, input logic [23:0] d1, input int bdly);
    ld0 = d0; ld1 = d1; ld = 1'b1;
    r0 = rises; v0 = valids;
    trigger = 1'b1;
    tick;
    ld = 1'b0; trigger = 1'b0;
    chk("cnv_latency", cnv, 1);
    busy = 1'b1;
    repeat (bdly - 1) tick;
    busy = 1'b0;
    for (int i = 0; i < 400 && valids == v0; i++) tick;
  endtask

  task automatic do_conv2(input logic [23:0] d0, input logic [23:0] d1);
    ld0 = d0; ld1 = d1; ld = 1'b1;
    r2 = rises2; v2 = valids2;
    trig2 = 1'b1;
    tick;
    ld = 1'b0; trig2 = 1'b0; busy2 = 1'b1;
    repeat (9) tick;
    busy2 = 1'b0;
    for (int i = 0; i < 400 && valids2 == v2; i++) tick;
    repeat (4) tick;
  endtask

  task automatic do_wr(input logic [14:0] a, input logic [7:0] d);
    addr = a; data = d; wr_valid = 1'b1;
    for (int i = 0; i < 200 && !ready; i++) tick;
    tick;
    wr_valid = 1'b0;
    r0 = rises;
    chk("wr_cs_low", cs, 0);
    for (int i = 0; i < 400 && !(rises - r0 == 24 && cs); i++) tick;
  endtask

  initial begin
    cv[0] = '{24'hA5A5A5, 24'h123456, 20, 48'h123456_A5A5A5};
    cv[1] = '{24'h000000, 24'hFFFFFF, 5, 48'hFFFFFF_000000};
    cv[2] = '{24'h800001, 24'h7FFFFE, 40, 48'h7FFFFE_800001};
    cv[3] = '{24'hFFFFFF, 24'h000001, 10, 48'h000001_FFFFFF};
    wv[0] = '{15'h7FFF, 8'hA5, 24'h7FFFA5};
    wv[1] = '{15'h0001, 8'h80, 24'h000180};

    repeat (3) tick;
    chk("rst_sck", sck, 0);
    chk("rst_cs", cs, 1);
    chk("rst_cnv", cnv, 1'b0);
    chk("rst_spi_reset", rstn, 0);
    chk("rst_outputs", {adc_data, valid, to, ready, sdi}, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !rstn; i++) begin
      tick;
      n++;
    end
    chk("rst_hold_cycles", n, 64);
    chk("ready_lag", ready, 0);
    tick;
    chk("ready_up", ready, 1);

    for (int i = 0; i < 4; i++) begin
      do_conv(cv[i].d0, cv[i].d1, cv[i].bdly);
      repeat (4) tick;
      chk("adc_data", adc_data, cv[i].exp);
      chk("sck_pulses", rises - r0, 24);
      chk("valid_pulses", valids - v0, 1);
      chk("cs_at_valid", cs_at_valid, 1);
    end

    addr = 15'h0020; data = 8'h0F; wr_valid = 1'b1;
    do_conv(24'h0F0F0F, 24'hF0F0F0, 20);
    chk("prio_valid", valids - v0, 1);
    chk("prio_data", adc_data, 48'hF0F0F0_0F0F0F);
    do_wr(15'h0020, 8'h0F);
    chk("prio_wr_frame", sdi_cap, 24'h00200F);
    chk("prio_wr_pulses", rises - r0, 24);
    chk("wr_keeps_data", adc_data, 48'hF0F0F0_0F0F0F);

    for (int i = 0; i < 2; i++) begin
      repeat (3) tick;
      do_wr(wv[i].a, wv[i].d);
      chk("wr_frame", sdi_cap, wv[i].exp);
      chk("wr_pulses", rises - r0, 24);
    end
    repeat (4) tick;

    v0 = valids;
    trigger = 1'b1;
    tick;
    trigger = 1'b0;
    busy = 1'b1;
    repeat (199) tick;
    chk("timeout_early", to, 0);
    repeat (100) tick;
    chk("timeout_set", to, 1);
    chk("timeout_no_valid", valids - v0, 0);
    chk("timeout_idle", ready, 1);
    busy = 1'b0;
    tick;
    do_conv(24'h3C3C3C, 24'hC3C3C3, 20);
    repeat (4) tick;
    chk("post_timeout_data", adc_data, 48'hC3C3C3_3C3C3C);
    chk("timeout_sticky", to, 1);

    do_conv2(24'h6C9A35, 24'h4E21B7);
    chk("l2_data", data2, 48'h4E21B7_6C9A35);
    chk("l2_pulses", rises2 - r2, 12);
    chk("l2_valid", valids2 - v2, 1);
`ifdef AD463X_TEST_PATTERN_EN
    tp = 1'b1;
    n = valids2;
    do_conv2(24'h111111, 24'h222222);
    chk("tp_frame0", data2, {24'(n + 1), 24'(n)});
    do_conv2(24'h111111, 24'h222222);
    chk("tp_frame1", data2, {24'(n + 2), 24'(n + 1)});
    tp = 1'b0;
`endif

    ld0 = 24'hFFFFFF; ld1 = 24'hFFFFFF; ld = 1'b1;
    v0 = valids; r0 = rises;
    trigger = 1'b1;
    tick;
    ld = 1'b0; trigger = 1'b0; busy = 1'b1;
    repeat (9) tick;
    busy = 1'b0;
    for (int i = 0; i < 300 && rises - r0 < 10; i++) tick;
    chk("abort_at_bit10", rises - r0, 10);
    reset = 1'b1;
    tick;
    chk("abort_sck", sck, 0);
    chk("abort_cs", cs, 1);
    chk("abort_spi_reset", rstn, 0);
    chk("abort_outputs", {adc_data, valid, to, ready, sdi, cnv}, 0);
    reset = 1'b0;
    repeat (80) tick;
    chk("abort_no_valid", valids - v0, 0);
    chk("abort_rst_release", rstn, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ad463x_acq_sequencer.md
Name: ad463x_acq_sequencer

Overview:
- Conversion and readout sequencer for AD463x dual-channel SAR ADCs on the RP expansion SPI pins (SCK, CS, CNV, RESET, SDI, BUSY, SDn lanes).
- Holds ADC reset after power-up, fires CNV on trigger, waits for BUSY to fall, clocks in NUM_ADCS×DATA_BITS bits and presents one parallel word with a valid pulse.
- Also serialises single-byte register writes to ADC SDI between conversions.
- Sits between the pin-level IO connect block and the RPSPMC signal path.

Parameters:
NUM_ADCS, 2, number of ADC channels, each with its own SDn lane group
NUM_LANES, 1, SDO lanes per ADC; legal values 1 or 2
DATA_BITS, 24, bits per conversion result; must be divisible by NUM_LANES
SCK_HALF, 2, aclk cycles per SCK half-period (≥1)
CNV_HIGH, 4, aclk cycles CNV is held high
RST_CYCLES, 64, aclk cycles SPI_reset is held low after reset
BUSY_TIMEOUT, 255, max aclk cycles spent waiting for BUSY to fall

Ports:
aclk  in  1  system clock
reset  in  1  synchronous, active-high reset
trigger  in  1  single-cycle conversion request
reg_wr_valid  in  1  register write request
reg_addr  in  15  ADC register address
reg_data  in  8  ADC register data
reg_wr_ready  out  1  high in IDLE only; a write is accepted when valid&&ready
adc_data  out  NUM_ADCS*DATA_BITS  results; ADC k occupies bits [k*DATA_BITS +: DATA_BITS]
adc_valid  out  1  one-cycle strobe when adc_data updates
busy_timeout  out  1  sticky; cleared by reset only
SPI_sck  out  1  serial clock, idles low
SPI_cs  out  1  chip select, active low
SPI_cnv  out  1  conversion start
SPI_reset  out  1  ADC reset, active low
SPI_SDI_data  out  1  serial data to ADC
SPI_busy  in  1  ADC busy, active high
SPI_SDn_data  in  NUM_ADCS*NUM_LANES  ADC data lanes; lane l of ADC k is bit k*NUM_LANES+l

Behaviour:
- Clock and reset: single clock aclk. Reset is synchronous and active-high on reset.
- Values while reset is asserted: SPI_sck=0, SPI_cs=1, SPI_cnv=0, SPI_reset=0, SPI_SDI_data=0, adc_data=0, adc_valid=0, busy_timeout=0, reg_wr_ready=0. The FSM enters RST_HOLD.
- Reset mid-operation aborts immediately to these values. No adc_valid is issued for the aborted frame.
- RST_HOLD: SPI_reset=0 for RST_CYCLES cycles, then SPI_reset=1 and go to IDLE.
- IDLE: reg_wr_ready=1.
  - trigger takes priority over reg_wr_valid when both are high in the same cycle; the write stays pending.
  - trigger goes to CNV. An accepted write goes to REG_WR.
  - trigger outside IDLE is ignored (dropped, not queued).
- CNV: SPI_cnv=1 for CNV_HIGH cycles, then SPI_cnv=0 and go to WAIT_BUSY.
- WAIT_BUSY:
  - SPI_busy is synchronised with two flops before use.
  - Synchronised BUSY low for one cycle → READ.
  - If the counter reaches BUSY_TIMEOUT: set busy_timeout, return to IDLE, no adc_valid.
- READ:
  - SPI_cs=0 one SCK_HALF before the first SCK rise.
  - Generates DATA_BITS/NUM_LANES SCK pulses.
  - SDn sampling: SDn bits are sampled in the aclk cycle where SPI_sck falls (high→low). Each lane shifts in MSB first.
  - With NUM_LANES=2, lane 0 supplies the more significant bit of each pair.
  - After the last fall: SPI_cs=1, adc_data updated and adc_valid=1 in the same cycle, then one SCK_HALF of CS-high quiet time, then IDLE.
- REG_WR:
  - SPI_cs=0. Shifts 24 bits on SPI_SDI_data MSB first: {1'b0 (write), reg_addr, reg_data}.
  - SDI changes when SCK falls. The first bit is set up SCK_HALF before the first rise.
  - Then CS high with the same quiet time, then IDLE. adc_data is unaffected.
- Timing: SCK frequency = aclk/(2*SCK_HALF).
- Trigger latency: trigger to CNV rising is 1 cycle.

Optional Feature:
- Macro: AD463X_TEST_PATTERN_EN.
- When defined: adds input test_pattern (1 bit). While it is high, each completed READ loads adc_data with a free-running DATA_BITS counter. The counter increments per frame, ADC k gets counter+k, and the lanes are ignored. All pin timing is unchanged.
- When undefined: the port and counter are absent, and adc_data always comes from the lanes.

Decomposition:
- Package ad463x_pkg holds:
  - FSM state enum: RST_HOLD, IDLE, CNV, WAIT_BUSY, READ, REG_WR, QUIET.
  - Register-write frame width (24).
  - Write-bit constant.
- Sub-module ad463x_sck_gen: SCK_HALF divider emitting sck, rise_tick and fall_tick, enabled by the FSM with a bit count.

Test Plan:
1. Reset release → SPI_reset low for exactly 64 cycles, then high; reg_wr_ready rises 1 cycle later.
2. trigger; BUSY low after 20 cycles; lanes drive 0xA5A5A5 / 0x123456 → adc_data=0x123456_A5A5A5, one adc_valid pulse, 24 SCK pulses, CS high after the last fall.
3. trigger and reg_wr_valid in the same cycle (addr 0x0020, data 0x0F) → conversion first, then SDI frame 0x00200F, 24 SCK pulses.
4. BUSY held high → busy_timeout=1 after 255 cycles, no adc_valid, next trigger still converts.
5. reset asserted mid-READ at bit 10 → outputs at reset values next cycle, no adc_valid.
6. NUM_LANES=2 → 12 SCK pulses, bit ordering per the lane-0-MSB rule; with AD463X_TEST_PATTERN_EN and test_pattern=1 → successive frames give counter values n, n+1.
